div_share_arbiter: RTL and testbench

- Shares one radix-2 divider instance among NREQ independent requesters.
- Arbitrates with round-robin priority and launches one operation at a time into the divider's valid_in/free/done interface.
- Routes q/r back to the granted requester over a valid/ready response handshake.
- Runs a watchdog on each divider operation and flags a hang.

---
 rtl/div_share_arbiter.sv | 135 +++++++++++++
 tb/tb_div_share_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_share_arbiter.sv
// div_share_arbiter: round-robin sharing of one divider among NREQ requesters,
// with an unbuffered valid/ready response path and a per-operation watchdog.
module div_share_arbiter #(
   parameter int NREQ    = 4,
   parameter int WIDTH   = 32,
   parameter int IDW     = 2,
   parameter int MAX_CYC = 64
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_dividend,
   input  logic [NREQ*WIDTH-1:0] req_divisor,
   input  logic [NREQ-1:0]       req_sign,
   output logic [NREQ-1:0]       rsp_valid,
   input  logic [NREQ-1:0]       rsp_ready,
   output logic [WIDTH-1:0]      rsp_q,
   output logic [WIDTH-1:0]      rsp_r,
   output logic [WIDTH-1:0]      div_zdividend,
   output logic [WIDTH-1:0]      div_zdivisor,
   output logic                  div_valid_in,
   output logic                  div_sign,
   input  logic                  div_free,
   input  logic                  div_done,
   input  logic [WIDTH-1:0]      div_q,
   input  logic [WIDTH-1:0]      div_r,
   output logic [IDW-1:0]        grant_id,
   output logic                  busy,
   output logic                  timeout_err
);
   localparam int CW = $clog2(MAX_CYC + 1);
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
   state_t state_q, state_d;
   logic [IDW-1:0] last_q, last_d, gnt_q, gnt_d, pick, idx;
   logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d, rq_q, rq_d, rr_q, rr_d;
   logic sgn_q, sgn_d, tmo_q, tmo_d, found, grant;
   logic [CW-1:0] cnt_q, cnt_d;
   // Search downwards so the requester closest after last_q wins.
   always_comb begin
      pick = '0;
      found = 1'b0;
      idx = '0;
      for (int i = NREQ; i >= 1; i--) begin
         idx = IDW'((int'(last_q) + i) % NREQ);
         if (req_valid[idx]) begin
            pick = idx;
            found = 1'b1;
         end
      end
   end
   assign grant = (state_q == IDLE) && div_free && found;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         last_q  <= IDW'(NREQ - 1);
         gnt_q   <= '0;
         dvd_q   <= '0;
         dvs_q   <= '0;
         sgn_q   <= 1'b0;
         rq_q    <= '0;
         rr_q    <= '0;
         tmo_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         dvd_q   <= dvd_d;
         dvs_q   <= dvs_d;
         sgn_q   <= sgn_d;
         rq_q    <= rq_d;
         rr_q    <= rr_d;
         tmo_q   <= tmo_d;
         cnt_q   <= cnt_d;
      end
   end
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      gnt_d   = gnt_q;
      dvd_d   = dvd_q;
      dvs_d   = dvs_q;
      sgn_d   = sgn_q;
      rq_d    = rq_q;
      rr_d    = rr_q;
      tmo_d   = tmo_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: if (grant) begin
            gnt_d   = pick;
            dvd_d   = req_dividend[int'(pick)*WIDTH +: WIDTH];
            dvs_d   = req_divisor[int'(pick)*WIDTH +: WIDTH];
            sgn_d   = req_sign[pick];
            state_d = ISSUE;
         end
         ISSUE: begin
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (div_done) begin
               rq_d    = div_q;
               rr_d    = div_r;
               state_d = RESP;
            end else if (cnt_d == CW'(MAX_CYC)) begin
               tmo_d   = 1'b1;
               rq_d    = '1;
               rr_d    = dvd_q;
               state_d = RESP;
            end
         end
         default: if (rsp_ready[gnt_q]) begin
            last_d  = gnt_q;
            state_d = IDLE;
         end
      endcase
   end
   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      if (grant) req_ready[pick] = 1'b1;
      if (state_q == RESP) rsp_valid[gnt_q] = 1'b1;
      div_valid_in  = state_q == ISSUE;
      busy          = state_q != IDLE;
      grant_id      = grant ? pick : gnt_q;
      div_zdividend = dvd_q;
      div_zdivisor  = dvs_q;
      div_sign      = sgn_q;
      rsp_q         = rq_q;
      rsp_r         = rr_q;
      timeout_err   = tmo_q;
   end
endmodule

// File: tb/tb_div_share_arbiter.sv
// tb_div_share_arbiter: directed bench with a transaction-level reference model
// and a behavioural divider that answers launches after a programmable latency.
module tb_div_share_arbiter;
   localparam int N = 4;
   localparam int W = 32;
   localparam int MC = 64;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [N-1:0] req_valid = '0, req_ready, req_sign = '0, rsp_valid, rsp_ready = '1;
   logic [N*W-1:0] req_dividend = '0, req_divisor = '0;
   logic [W-1:0] rsp_q, rsp_r, div_zdividend, div_zdivisor, div_q = '0, div_r = '0;
   logic div_valid_in, div_sign, div_free = 1'b1, div_done = 1'b0, busy, timeout_err;
   logic [1:0] grant_id;
   always #5 clk = ~clk;

   div_share_arbiter #(.NREQ(N), .WIDTH(W), .IDW(2), .MAX_CYC(MC)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_dividend(req_dividend), .req_divisor(req_divisor), .req_sign(req_sign),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_q(rsp_q), .rsp_r(rsp_r),
      .div_zdividend(div_zdividend), .div_zdivisor(div_zdivisor),
      .div_valid_in(div_valid_in), .div_sign(div_sign), .div_free(div_free),
      .div_done(div_done), .div_q(div_q), .div_r(div_r), .grant_id(grant_id),
      .busy(busy), .timeout_err(timeout_err));

   typedef struct {int id; logic [W-1:0] q; logic [W-1:0] r;} rsp_t;
   rsp_t rlog[$];
   int gl[$];
   int n_chk = 0, n_pass = 0;
   bit go = 0;

   function automatic void chk(string nm, logic [63:0] a, logic [63:0] e);
      n_chk++;
      if (a === e) n_pass++;
      else $display("FAIL %s got %0h want %0h", nm, a, e);
   endfunction

   function automatic logic [63:0] divf(logic [W-1:0] a, logic [W-1:0] b, logic s);
      if (s) return {W'($signed(a) / $signed(b)), W'($signed(a) % $signed(b))};
      return {a / b, a % b};
   endfunction

   function automatic int rr_pick(int last, logic [N-1:0] v);
      for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   // Reference: one outstanding transaction at a time, tracked by its phase.
   int ph = 0, own = 0, last = N - 1, wc = 0;
   bit etmo = 0, esg = 0, mov = 0;
   logic [W-1:0] edvd = '0, edvs = '0, cq = '0, cr = '0, mq = '0, mr = '0;
   always @(negedge clk) begin
      logic [N-1:0] erdy;
      int g;
      g = rr_pick(last, req_valid);
      erdy = (ph == 0 && div_free === 1'b1 && g >= 0) ? N'(1 << g) : '0;
      if (go) begin
         chk("req_ready", req_ready, erdy);
         chk("div_valid_in", div_valid_in, ph == 1);
         chk("busy", busy, ph != 0);
         chk("rsp_valid", rsp_valid, ph == 3 ? N'(1 << own) : '0);
         chk("timeout_err", timeout_err, etmo);
         chk("div_zdividend", div_zdividend, edvd);
         chk("div_zdivisor", div_zdivisor, edvs);
         chk("div_sign", div_sign, esg);
         if (erdy != 0) chk("grant_id_grant", grant_id, g);
         if (ph != 0) chk("grant_id", grant_id, own);
         if (ph == 3) begin
            chk("rsp_q", rsp_q, mq);
            chk("rsp_r", rsp_r, mr);
         end
      end
      if (rst) begin
         ph = 0; last = N - 1; etmo = 0; edvd = '0; edvs = '0; esg = 0;
      end else case (ph)
         0: if (erdy != 0) begin
            own = g;
            edvd = req_dividend[g*W +: W];
            edvs = req_divisor[g*W +: W];
            esg = req_sign[g];
            {cq, cr} = mov ? {32'hDEAD, 32'hBEEF} : divf(edvd, edvs, esg);
            ph = 1;
         end
         1: begin ph = 2; wc = 0; end
         2: begin
            wc++;
            if (div_done) begin mq = cq; mr = cr; ph = 3; end
            else if (wc == MC) begin etmo = 1; mq = '1; mr = edvd; ph = 3; end
         end
         default: if (rsp_ready[own]) begin
            rlog.push_back('{own, rsp_q, rsp_r});
            last = own;
            ph = 0;
         end
      endcase
   end

   // Stimulus side: requesters and the behavioural divider, one driver process.
   logic [N-1:0] keep = '0;
   int busyc = 0, lat = 3, ngrant = 0, nissue = 0, ndone = 0;
   bit hang = 0, launched = 0;
   logic [W-1:0] oa = '0, ob = '0;
   logic os = 0;

   task automatic tick();
      logic l, s;
      logic [W-1:0] a, b;
      logic [N-1:0] hs;
      @(negedge clk);
      l = div_valid_in; a = div_zdividend; b = div_zdivisor; s = div_sign;
      hs = req_valid & req_ready;
      if (div_done) ndone++;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (hs[i]) begin gl.push_back(i); ngrant++; end
      req_valid = req_valid & ~(hs & ~keep);
      launched = l;
      if (l) nissue++;
      div_done = 1'b0;
      if (l) begin busyc = lat; oa = a; ob = b; os = s; end
      else if (busyc > 0) begin
         busyc--;
         if (busyc == 0 && !hang) begin
            {div_q, div_r} = mov ? {32'hDEAD, 32'hBEEF} : divf(oa, ob, os);
            div_done = 1'b1;
         end
      end
      div_free = busyc == 0;
   endtask

   task automatic put(int i, logic [W-1:0] a, logic [W-1:0] b);
      req_dividend[i*W +: W] = a;
      req_divisor[i*W +: W] = b;
      req_sign[i] = 1'b0;
      req_valid[i] = 1'b1;
   endtask

   task automatic do_reset();
      req_valid = '0; keep = '0; rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_log(int n);
      int k = 0;
      while (rlog.size() < n && k < 500) begin tick(); k++; end
      chk("wait_rsp", rlog.size() >= n, 1);
   endtask

   task automatic wait_until_launch();
      int k = 0;
      launched = 0;
      while (!launched && k < 50) begin tick(); k++; end
      chk("wait_launch", launched, 1);
   endtask

   initial begin
      int b, n, early, g0, d0, nzr;
      tick();
      go = 1;
      tick();
      rst = 1'b0;
      // unsigned 100/7
      put(0, 100, 7);
      wait_log(1);
      chk("t1_id", rlog[0].id, 0);
      chk("t1_q", rlog[0].q, 14);
      chk("t1_r", rlog[0].r, 2);
      tick();
      chk("t1_busy", busy, 0);
      chk("t1_grants", ngrant, 1);
      chk("t1_issues", nissue, 1);
      // all four at once
      do_reset();
      b = rlog.size();
      put(0, 10, 3); put(1, 20, 3); put(2, 30, 3); put(3, 40, 3);
      wait_log(b + 4);
      for (int i = 0; i < 4; i++) begin
         logic [W-1:0] xq [4] = '{3, 6, 10, 13};
         logic [W-1:0] xr [4] = '{1, 2, 0, 1};
         chk("t2_id", rlog[b+i].id, i);
         chk("t2_q", rlog[b+i].q, xq[i]);
         chk("t2_r", rlog[b+i].r, xr[i]);
      end
      // continuous 1 and 3 alternate
      do_reset();
      b = gl.size();
      keep = 4'b1010;
      put(1, 9, 2); put(3, 8, 3);
      n = 0;
      while (gl.size() < b + 4 && n < 500) begin tick(); n++; end
      req_valid = '0; keep = '0;
      n = 0;
      while (busy && n < 100) begin tick(); n++; end
      chk("t3_idle", busy, 0);
      for (int i = 0; i < 4; i++) chk("t3_order", gl[b+i], (i % 2) ? 3 : 1);
      do_reset();
      b = gl.size();
      put(0, 7, 7); put(2, 6, 4);
      wait_log(rlog.size() + 2);
      chk("t3_first", gl[b], 0);
      chk("t3_second", gl[b+1], 2);
      // held response
      mov = 1;
      rsp_ready = 4'b1011;
      put(2, 1000, 9);
      n = 0;
      while (!rsp_valid[2] && n < 100) begin tick(); n++; end
      chk("t4_rsp", rsp_valid, 4'b0100);
      put(0, 5, 2);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t4_hold_v", rsp_valid, 4'b0100);
         chk("t4_hold_q", rsp_q, 32'hDEAD);
         chk("t4_hold_r", rsp_r, 32'hBEEF);
         chk("t4_no_issue", div_valid_in, 0);
      end
      b = rlog.size();
      rsp_ready = '1; mov = 0;
      wait_log(b + 2);
      chk("t4_q", rlog[b].q, 32'hDEAD);
      chk("t4_next_id", rlog[b+1].id, 0);
      chk("t4_next_q", rlog[b+1].q, 2);
      chk("t4_next_r", rlog[b+1].r, 1);
      // watchdog
      hang = 1;
      put(1, 32'h55, 3);
      wait_until_launch();
      n = 0;
      while (!timeout_err && n < 200) begin tick(); n++; end
      chk("t5_latency", n, 64);
      b = rlog.size();
      wait_log(b + 1);
      chk("t5_q", rlog[b].q, 32'hFFFF_FFFF);
      chk("t5_r", rlog[b].r, 32'h55);
      hang = 0;
      put(2, 100, 7);
      wait_log(b + 2);
      chk("t5_ok_q", rlog[b+1].q, 14);
      chk("t5_sticky", timeout_err, 1);
      do_reset();
      chk("t5_cleared", timeout_err, 0);
      // reset mid-WAIT
      lat = 20;
      put(0, 50, 5);
      wait_until_launch();
      tick(); tick(); tick();
      rst = 1'b1; req_valid = '0;
      tick();
      rst = 1'b0;
      chk("t6_busy", busy, 0);
      chk("t6_rsp", rsp_valid, 0);
      chk("t6_dvd", div_zdividend, 0);
      chk("t6_gid", grant_id, 0);
      chk("t6_vin", div_valid_in, 0);
      b = rlog.size();
      put(1, 50, 5);
      g0 = ngrant; d0 = ndone; early = 0; nzr = 0; n = 0;
      while (ndone == d0 && n < 100) begin
         tick(); n++;
         if (rsp_valid != 0) nzr++;
         if (ndone == d0 && ngrant != g0) early++;
      end
      chk("t6_late_done", ndone, d0 + 1);
      chk("t6_no_rsp", nzr, 0);
      chk("t6_no_early_grant", early, 0);
      lat = 3;
      wait_log(b + 1);
      chk("t6_id", rlog[b].id, 1);
      chk("t6_q", rlog[b].q, 10);
      chk("t6_r", rlog[b].r, 0);
      tick();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
